capture_dump: RTL and testbench

CAPTURE_DUMP -- requirements
Module: capture_dump

---
 rtl/capture_pkg.sv | 9 +
 rtl/circ_addr_cnt.sv | 19 +
 rtl/capture_dump.sv | 69 ++++++
 tb/tb_capture_dump.sv | 122 ++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared sizing defaults, dump FSM states and circular-address helper.
package capture_pkg;
  localparam int DEF_ENTRIES = 384;
  localparam int DEF_LOG2 = 9;
  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, TXW, DONE} dump_state_e;
  function automatic int wrap_inc(input int a, input int n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction
endpackage

// File: rtl/circ_addr_cnt.sv
// circ_addr_cnt: loadable address counter that wraps at ENTRIES rather than a power of two.
module circ_addr_cnt import capture_pkg::*; #(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int LOG2 = DEF_LOG2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [LOG2-1:0] load_val,
  output logic [LOG2-1:0] addr
);
  logic [LOG2-1:0] addr_q, addr_d;
  always_comb addr_d = load ? load_val : inc ? LOG2'(wrap_inc(int'(addr_q), ENTRIES)) : addr_q;
  always_ff @(posedge clk)
    if (rst) addr_q <= '0;
    else addr_q <= addr_d;
  assign addr = addr_q;
endmodule

// File: rtl/capture_dump.sv
// capture_dump: streams the circular capture buffer oldest-first to the UART, one byte per tx_done.
module capture_dump import capture_pkg::*; #(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int LOG2 = DEF_LOG2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump,
  input  logic            capture_done,
  input  logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic            ren,
  input  logic [7:0]      rdata,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  output logic            busy,
  output logic            dump_done
);
  dump_state_e state_q, state_d;
  logic [LOG2:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic accept, step, last;
  assign accept = (state_q == IDLE) && dump && capture_done;
  assign step = (state_q == TXW) && tx_done;
  assign last = cnt_q == (LOG2+1)'(ENTRIES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = accept ? RD : IDLE;
      RD: state_d = LAT;
      LAT: state_d = SEND;
      SEND: state_d = TXW;
      TXW: state_d = tx_done ? (last ? DONE : RD) : TXW;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    tx_data_d = (state_q == LAT) ? rdata : tx_data_q;
  end
  always_comb begin
    ren = state_q == RD;
    trmt = state_q == SEND;
    busy = state_q != IDLE;
    dump_done = state_q == DONE;
  end
  // start oldest-first: the slot just after the newest sample
  circ_addr_cnt #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_addr (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .inc(step),
    .load_val(LOG2'(wrap_inc(int'(waddr), ENTRIES))),
    .addr(raddr)
  );
  assign tx_data = tx_data_q;
endmodule

// File: tb/tb_capture_dump.sv
// tb_capture_dump: directed dumps with a byte-wise RAM/UART model and hand-derived address sequence.
module tb_capture_dump;
  localparam int ENTRIES = 384;
  logic clk = 0, rst, dump, capture_done, ren, trmt, tx_done, busy, dump_done;
  logic [8:0] waddr, raddr;
  logic [7:0] rdata, tx_data;
  int checks = 0, failures = 0;
  int n, d;
  logic bad;
  always #5 clk = ~clk;
  capture_dump dut (
    .clk(clk), .rst(rst), .dump(dump), .capture_done(capture_done),
    .waddr(waddr), .raddr(raddr), .ren(ren), .rdata(rdata),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .busy(busy), .dump_done(dump_done)
  );
  // RAM preloaded with data = addr[7:0], one-cycle read latency
  always @(posedge clk) if (ren) rdata <= raddr[7:0];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int nxt(input int a);
    return (a == ENTRIES - 1) ? 0 : a + 1;
  endfunction
  task automatic run(input int wa, input int inj, input int rst_at, output int nb, output int dn);
    int exp, cd, lat, cyc;
    bit stop, injected;
    waddr = 9'(wa); capture_done = 1; dump = 1;
    exp = nxt(wa); nb = 0; dn = 0; cd = -1; lat = 0; cyc = 0; stop = 0; injected = 0;
    while (cyc < 20000 && dn == 0 && !stop) begin
      @(negedge clk);
      cyc++; lat++;
      dump = 0; tx_done = 0; waddr = 9'd7; capture_done = 0;
      if (ren) check("range", int'(raddr < 9'(ENTRIES)), 1);
      if (trmt) begin
        check("lat", lat, 3);
        check("addr", int'(raddr), exp);
        check("data", int'(tx_data), exp & 255);
        nb++; cd = 10;
      end
      if (dump_done) dn++;
      if (ren && nb == inj && !injected) begin
        dump = 1; capture_done = 1; tx_done = 1; injected = 1;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          check("hold_addr", int'(raddr), exp);
          check("hold_data", int'(tx_data), exp & 255);
          tx_done = 1; lat = 0; exp = nxt(exp);
        end
      end
      if (rst_at >= 0 && nb == rst_at && cd == 5) begin
        rst = 1; dump = 1; capture_done = 1; waddr = 9'(wa);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_trmt", int'(trmt), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_ren", int'(ren), 0);
        check("rst_data", int'(tx_data), 0);
        rst = 0; dump = 0; capture_done = 0;
        @(negedge clk);
        check("rst_noacc", int'(busy), 0);
        stop = 1;
      end
    end
  endtask
  task automatic idle_after();
    int extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (dump_done) extra++;
    end
    check("idle_busy", int'(busy), 0);
    check("extra_done", extra, 0);
  endtask
  initial begin
    rst = 1; dump = 0; capture_done = 0; tx_done = 0; waddr = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_ren", int'(ren), 0);
    check("reset_trmt", int'(trmt), 0);
    check("reset_done", int'(dump_done), 0);
    check("reset_raddr", int'(raddr), 0);
    check("reset_data", int'(tx_data), 0);
    rst = 0;
    @(negedge clk);
    run(100, 10, -1, n, d);
    check("w100_bytes", n, ENTRIES);
    check("w100_dones", d, 1);
    idle_after();
    run(383, -1, -1, n, d);
    check("w383_bytes", n, ENTRIES);
    check("w383_dones", d, 1);
    idle_after();
    run(5, -1, -1, n, d);
    check("w5_bytes", n, ENTRIES);
    check("w5_dones", d, 1);
    idle_after();
    waddr = 20; capture_done = 0; dump = 1;
    @(negedge clk);
    dump = 0; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy | ren | trmt) bad = 1;
    end
    check("nocap", int'(bad), 0);
    run(100, -1, 200, n, d);
    check("rst_bytes", n, 200);
    check("rst_dones", d, 0);
    run(250, -1, -1, n, d);
    check("w250_bytes", n, ENTRIES);
    check("w250_dones", d, 1);
    idle_after();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
